// File: rtl/arch_defs_pkg.sv
// Shared SAP-2 architecture definitions: UART receiver state encoding, I/O register
// addresses, STATUS bit positions and the baud divider helper.
package arch_defs_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      WAIT_HI
   } uart_rx_state_t;

   localparam logic UART_REG_DATA   = 1'b0;
   localparam logic UART_REG_STATUS = 1'b1;

   localparam int unsigned STAT_RX_VALID    = 0;
   localparam int unsigned STAT_OVERRUN     = 1;
   localparam int unsigned STAT_FRAMING_ERR = 2;
   localparam int unsigned STAT_PARITY_ERR  = 3;

   // Clocks per oversample tick, floored and never below one.
   function automatic int unsigned uart_div(input int unsigned clk_hz,
                                            input int unsigned baud,
                                            input int unsigned oversample);
      int unsigned d;
      d = clk_hz / (baud * oversample);
      return (d == 0) ? 1 : d;
   endfunction

endpackage

// File: rtl/uart_baud_tick_gen.sv
// Free-running baud tick generator: one-cycle pulse on tick every DIV clocks.
// Shared by the UART transmit and receive paths.
module uart_baud_tick_gen #(
   parameter int unsigned DIV = 1
) (
   input  logic clk,
   input  logic reset_n,
   output logic tick
);

   localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q;
   logic          tick_q;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else if (cnt_q == LAST) begin
         cnt_q  <= '0;
         tick_q <= 1'b1;
      end else begin
         cnt_q  <= cnt_q + 1'b1;
         tick_q <= 1'b0;
      end
   end

   assign tick = tick_q;

endmodule

// File: rtl/uart_rx_mmio.sv
// Memory-mapped 8N1 UART receiver with DATA/STATUS registers on the SAP-2 I/O bus.
// Define UART_RX_PARITY_EN for 8E1 frames with a live parity_err STATUS bit.
module uart_rx_mmio
   import arch_defs_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ = 20_000_000,
   parameter int unsigned BAUD_RATE   = 115_200,
   parameter int unsigned OVERSAMPLE  = 16
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       uart_rx,
   input  logic       bus_addr,
   input  logic       bus_rd_en,
   output logic [7:0] bus_rd_data,
   output logic       rx_irq
);

   localparam int unsigned DIV = uart_div(CLK_FREQ_HZ, BAUD_RATE, OVERSAMPLE);
   localparam int unsigned TCW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   localparam logic [TCW-1:0] LAST_TICK = TCW'(OVERSAMPLE - 1);
   localparam logic [TCW-1:0] HALF_TICK = TCW'((OVERSAMPLE / 2 > 0) ? OVERSAMPLE / 2 - 1 : 0);

   logic tick;

   uart_baud_tick_gen #(
      .DIV (DIV)
   ) u_tick_gen (
      .clk     (clk),
      .reset_n (reset_n),
      .tick    (tick)
   );

   logic rx_meta_q, rx_s_q;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= uart_rx;
         rx_s_q    <= rx_meta_q;
      end
   end

   uart_rx_state_t state_q;
   logic [TCW-1:0] tick_cnt_q;
   logic [2:0]     bit_cnt_q;
   logic [7:0]     shift_q;
   logic           commit_q;
   logic           commit_ferr_q;
`ifdef UART_RX_PARITY_EN
   logic           perr_pend_q;
   logic           commit_perr_q;
`endif

   // Sampling points sit at mid-bit: half a bit after the start edge, then whole bits.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         tick_cnt_q    <= '0;
         bit_cnt_q     <= '0;
         shift_q       <= '0;
         commit_q      <= 1'b0;
         commit_ferr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
         perr_pend_q   <= 1'b0;
         commit_perr_q <= 1'b0;
`endif
      end else begin
         commit_q      <= 1'b0;
         commit_ferr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
         commit_perr_q <= 1'b0;
`endif
         if (tick) begin
            unique case (state_q)
               IDLE: begin
                  tick_cnt_q <= '0;
                  if (!rx_s_q) state_q <= START;
               end
               START: begin
                  if (tick_cnt_q == HALF_TICK) begin
                     tick_cnt_q <= '0;
                     bit_cnt_q  <= '0;
                     state_q    <= rx_s_q ? IDLE : DATA;
                  end else begin
                     tick_cnt_q <= tick_cnt_q + 1'b1;
                  end
               end
               DATA: begin
                  if (tick_cnt_q == LAST_TICK) begin
                     tick_cnt_q <= '0;
                     shift_q    <= {rx_s_q, shift_q[7:1]};
                     bit_cnt_q  <= bit_cnt_q + 1'b1;
                     if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_q <= PARITY;
`else
                        state_q <= STOP;
`endif
                     end
                  end else begin
                     tick_cnt_q <= tick_cnt_q + 1'b1;
                  end
               end
`ifdef UART_RX_PARITY_EN
               PARITY: begin
                  if (tick_cnt_q == LAST_TICK) begin
                     tick_cnt_q  <= '0;
                     perr_pend_q <= (rx_s_q != ^shift_q);
                     state_q     <= STOP;
                  end else begin
                     tick_cnt_q <= tick_cnt_q + 1'b1;
                  end
               end
`endif
               STOP: begin
                  if (tick_cnt_q == LAST_TICK) begin
                     tick_cnt_q    <= '0;
                     commit_q      <= 1'b1;
                     commit_ferr_q <= !rx_s_q;
`ifdef UART_RX_PARITY_EN
                     commit_perr_q <= perr_pend_q;
`endif
                     state_q       <= rx_s_q ? IDLE : WAIT_HI;
                  end else begin
                     tick_cnt_q <= tick_cnt_q + 1'b1;
                  end
               end
               WAIT_HI: begin
                  tick_cnt_q <= '0;
                  if (rx_s_q) state_q <= IDLE;
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   logic [7:0] data_q;
   logic [7:0] rd_data_q;
   logic       rx_valid_q;
   logic       overrun_q;
   logic       framing_err_q;
   logic       parity_err;
   logic [7:0] status;
   logic       rd_data_stb;
   logic       rd_stat_stb;

   assign rd_data_stb = bus_rd_en && (bus_addr == UART_REG_DATA);
   assign rd_stat_stb = bus_rd_en && (bus_addr == UART_REG_STATUS);

`ifdef UART_RX_PARITY_EN
   logic parity_err_q;

   always_ff @(posedge clk) begin
      if (!reset_n) parity_err_q <= 1'b0;
      else          parity_err_q <= (commit_q && commit_perr_q) || (parity_err_q && !rd_stat_stb);
   end

   assign parity_err = parity_err_q;
`else
   assign parity_err = 1'b0;
`endif

   always_comb begin
      status                   = '0;
      status[STAT_RX_VALID]    = rx_valid_q;
      status[STAT_OVERRUN]     = overrun_q;
      status[STAT_FRAMING_ERR] = framing_err_q;
      status[STAT_PARITY_ERR]  = parity_err;
   end

   // A commit coinciding with a DATA read wins: valid stays set, no overrun.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         data_q        <= '0;
         rd_data_q     <= '0;
         rx_valid_q    <= 1'b0;
         overrun_q     <= 1'b0;
         framing_err_q <= 1'b0;
      end else begin
         if (bus_rd_en) rd_data_q <= (bus_addr == UART_REG_STATUS) ? status : data_q;
         if (commit_q) begin
            data_q     <= shift_q;
            rx_valid_q <= 1'b1;
            overrun_q  <= !rd_data_stb && (rx_valid_q || overrun_q);
         end else if (rd_data_stb) begin
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
         end
         framing_err_q <= (commit_q && commit_ferr_q) || (framing_err_q && !rd_stat_stb);
      end
   end

   assign bus_rd_data = rd_data_q;
   assign rx_irq      = rx_valid_q;

endmodule
